multiplier_datapath: RTL
========================

# multiplier_datapath

Register-and-arithmetic datapath for the 8-bit signed shift-add multiplier. It executes the control strobes issued by the multiplier control FSM (LD_XA, LD_B, Shift_EN, Cnt_EN, Clr_XA, SUB_ADD). It holds the X:A:B product registers and the 3-bit iteration counter, and returns M and count to that controller. The block sits between the switch input Din and the hex-display outputs.

## Interface
- No parameters; operand width fixed at 8 bits.
- Clk  in  1  sole clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Din  in  8  multiplicand / multiplier operand (two's complement).
- LD_B  in  1  load B from Din.
- LD_XA  in  1  load X:A with adder result.
- SUB_ADD  in  1  adder mode: 0 = A+Din, 1 = A−Din.
- Shift_EN  in  1  arithmetic right shift of {X,A,B}.
- Cnt_EN  in  1  increment count.
- Clr_XA  in  1  clear X and A.
- Aval  out  8  register A (product high byte).
- Bval  out  8  register B (product low byte / multiplier).
- X  out  1  sign-extension bit.
- M  out  1  equals Bval[0].
- count  out  3  iteration counter.
- Done  out  1  one-cycle pulse on count wrap (see Configuration).

## Operation
- Registers: X (1), A (8), B (8), count (3), Done (1). All outputs are driven directly from registers. There is no combinational path from any input to any output.
- Adder is 9-bit: sum9 = {A[7],A} + (SUB_ADD ? ~{Din[7],Din} + 1 : {Din[7],Din}). Carry out of bit 8 is discarded.
- X:A update priority per cycle, highest first:
  - Clr_XA: X=0, A=0.
  - LD_XA: X=sum9[8], A=sum9[7:0].
  - Shift_EN: X=X, A={X,A[7:1]}.
  - None asserted: hold.
- B update priority: LD_B (B=Din) > Shift_EN (B={A[0],B[7:1]}, using pre-edge A) > hold.
- If Clr_XA or LD_XA coincides with Shift_EN, the shift is suppressed for X, A and B. B still loads if LD_B is asserted.
- count: on Cnt_EN, count=count+1 mod 8; wraps 7→0. Clr_XA does not affect count. Only reset or wrap returns it to 0.
- The adder operates unconditionally on LD_XA. The decision to add when M=1, and to subtract on the final iteration, belongs to the controller.

## Timing
- Reset values: X=0, A=0x00, B=0x00, count=0, M=0, Done=0.
- Reset is asynchronous. Asserting Reset_n=0 mid-multiply clears all state immediately. The first update after deassertion occurs at the next rising edge.
- Every strobe has 1-cycle latency: its effect is visible on outputs in the cycle after the edge that sampled it.
- M updates in the same cycle as B. The controller sees the new M one cycle after Shift_EN or LD_B.
- A complete multiply is Clr_XA, then 8× (optional LD_XA, Shift_EN + Cnt_EN). The product is {Aval,Bval}, and count returns to 0.

## Configuration
- MULTIPLIER_DATAPATH_DONE_EN defined:
  - Done is registered and goes to 1 for exactly one cycle after an edge where Cnt_EN=1 and count=7.
  - Done=0 otherwise.
  - Reset clears Done.
- MULTIPLIER_DATAPATH_DONE_EN undefined: the Done port remains present and is tied to constant 0. No additional flops are implied.

## Test plan
- Reset: load A=0x5A, B=0x33, count=5, then pulse Reset_n=0 between edges → all outputs 0 immediately, without waiting for a clock edge.
- Add/subtract:
  - Clr_XA, then LD_XA with SUB_ADD=0, Din=0xC5 → X=1, Aval=0xC5.
  - From A=0x7F, LD_XA with SUB_ADD=0, Din=0x7F → X=0, Aval=0xFE.
  - From A=0x80, LD_XA with SUB_ADD=1, Din=0x80 → X=0, Aval=0x00.
- Shift: X=1, A=0x81, B=0x03, then Shift_EN → X=1, Aval=0xC0, Bval=0x81, M=1.
- Priority:
  - Clr_XA+LD_XA+Shift_EN together → X=0, A=0, B unchanged.
  - LD_B+Shift_EN with Din=0x07 → Bval=0x07, A shifted.
- Count wrap: 8 consecutive Cnt_EN pulses from 0 → count 1…7,0. With MULTIPLIER_DATAPATH_DONE_EN defined, Done=1 only in the cycle after the 7→0 edge; without it, Done stays 0.
- Full multiply: B=0x07, Din=0xFD (−3), controller-style sequence of 7 add/shift iterations plus a final subtract iteration → {Aval,Bval}=0xFFEB (−21), X=1, count=0.

Source files
------------

// File: rtl/multiplier_datapath.sv
// multiplier_datapath
// Register-and-arithmetic datapath for an 8-bit signed shift-add multiplier.
// Holds the X:A:B product registers and a 3-bit iteration counter, and
// executes the single-cycle control strobes issued by the control FSM.
//
// Strobe semantics: every control input is a level sampled on the rising
// edge of Clk; there is no handshake, and the effect of a strobe is visible
// on the outputs in the cycle after the edge that sampled it.
//
// Optional feature: define MULTIPLIER_DATAPATH_DONE_EN to get a registered
// one-cycle Done pulse on the 7->0 counter wrap. When it is undefined, Done
// is tied to 0 and no flop is built for it.

module multiplier_datapath (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Din,
    input  logic       LD_B,
    input  logic       LD_XA,
    input  logic       SUB_ADD,
    input  logic       Shift_EN,
    input  logic       Cnt_EN,
    input  logic       Clr_XA,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       M,
    output logic [2:0] count,
    output logic       Done
);

    // 9-bit sign-extended adder operands and result
    logic [8:0] a_ext;
    logic [8:0] d_ext;
    logic [8:0] operand;
    logic [8:0] sum9;

    // A shift only takes effect when neither clear nor load claims X:A this
    // cycle; the same suppression applies to B so the three registers never
    // shift out of step with each other.
    logic shift_ok;

    // Adder: A + Din or A - Din, with carry out of bit 8 discarded
    always_comb begin
        a_ext    = {Aval[7], Aval};
        d_ext    = {Din[7], Din};
        operand  = SUB_ADD ? (~d_ext + 9'd1) : d_ext;
        sum9     = a_ext + operand;
        shift_ok = Shift_EN && !Clr_XA && !LD_XA;
    end

    // X:A update: clear > load from adder > arithmetic shift > hold
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            X    <= 1'b0;
            Aval <= 8'h00;
        end else if (Clr_XA) begin
            X    <= 1'b0;
            Aval <= 8'h00;
        end else if (LD_XA) begin
            X    <= sum9[8];
            Aval <= sum9[7:0];
        end else if (Shift_EN) begin
            X    <= X;
            Aval <= {X, Aval[7:1]};
        end
    end

    // B update: load from Din > shift in pre-edge A[0] > hold
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Bval <= 8'h00;
        end else if (LD_B) begin
            Bval <= Din;
        end else if (shift_ok) begin
            Bval <= {Aval[0], Bval[7:1]};
        end
    end

    // Iteration counter: increments modulo 8, untouched by Clr_XA
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= 3'd0;
        end else if (Cnt_EN) begin
            count <= count + 3'd1;
        end
    end

    // M is the multiplier LSB the controller inspects each iteration
    assign M = Bval[0];

`ifdef MULTIPLIER_DATAPATH_DONE_EN
    // Done pulses for one cycle after the edge that wraps count 7->0
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Done <= 1'b0;
        end else begin
            Done <= Cnt_EN && (count == 3'd7);
        end
    end
`else
    assign Done = 1'b0;
`endif

endmodule
